// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: bit-serial right-to-left square-and-multiply modular exponentiation, operand^exp mod n
// Ports: clk, reset (sync, active-high); ready/mode/e/d/n/C_in request inputs sampled in IDLE;
//        m_out result, valid one-cycle done pulse, err rejected request, busy from accept until after valid.
module rsa_modexp_core #(
    parameter int WIDTH      = 256,
    parameter bit BIG_ENDIAN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] C_in,
    output logic [WIDTH-1:0] m_out,
    output logic             valid,
    output logic             err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, NEXT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] n_q, r_q, b_q, exp_q, acc1, acc2, acc1_nx, acc2_nx, r_new;
    logic [CW-1:0]    cnt;
    logic             bad_op, last;

    function automatic logic [WIDTH-1:0] ord(input logic [WIDTH-1:0] v);
        ord = v;
        if (BIG_ENDIAN)
            for (int j = 0; j < WIDTH/8; j++) ord[8*j +: 8] = v[WIDTH-8-8*j +: 8];
    endfunction

    // One interleaved step: acc = 2*acc (+ b if bit set), reduced mod m; two extra bits hold the pre-reduction sums
    function automatic logic [WIDTH-1:0] mstep(input logic [WIDTH-1:0] acc, input logic a_bit,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] t;
        t = {1'b0, acc, 1'b0};
        t = (t >= {2'b0, m}) ? t - {2'b0, m} : t;
        t = a_bit ? t + {2'b0, b} : t;
        t = (t >= {2'b0, m}) ? t - {2'b0, m} : t;
        return t[WIDTH-1:0];
    endfunction

    assign acc1_nx = mstep(acc1, r_q[cnt], b_q, n_q);
    assign acc2_nx = mstep(acc2, b_q[cnt], b_q, n_q);
    assign bad_op  = (b_q >= n_q) || (n_q[WIDTH-1:1] == '0);
    assign last    = exp_q[WIDTH-1:1] == '0;
    assign r_new   = exp_q[0] ? acc1 : r_q;
    assign valid   = state == DONE;
    assign busy    = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ready ? LOAD : IDLE;
            LOAD:    state_nx = (bad_op || exp_q == '0) ? DONE : MUL;
            MUL:     state_nx = (cnt == '0) ? NEXT : MUL;
            NEXT:    state_nx = last ? DONE : MUL;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= '0;
            r_q   <= '0;
            b_q   <= '0;
            exp_q <= '0;
            acc1  <= '0;
            acc2  <= '0;
            cnt   <= '0;
            m_out <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ready) begin
                    n_q   <= n;
                    b_q   <= ord(C_in);
                    exp_q <= mode ? d : e;
                    err   <= 1'b0;
                end
                LOAD: begin
                    r_q  <= WIDTH'(1);
                    acc1 <= '0;
                    acc2 <= '0;
                    cnt  <= CW'(WIDTH-1);
                    if (bad_op) begin
                        err   <= 1'b1;
                        m_out <= '0;
                    end else if (exp_q == '0) m_out <= ord(WIDTH'(1));
                end
                MUL: begin
                    acc1 <= acc1_nx;
                    acc2 <= acc2_nx;
                    cnt  <= cnt - 1'b1;
                end
                NEXT: begin
                    r_q   <= r_new;
                    b_q   <= acc2;
                    exp_q <= exp_q >> 1;
                    acc1  <= '0;
                    acc2  <= '0;
                    cnt   <= CW'(WIDTH-1);
                    if (last) m_out <= ord(r_new);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: vector table, hand sequences and random back-to-back regression against a reference model
module tb_rsa_modexp_core;
    logic        clk = 1'b0, reset = 1'b1, mode_i = 1'b0;
    logic [2:0]  rdy = '0, vld, er, bsy;
    logic [31:0] e_i = '0, d_i = '0, n_i = '0, c_i = '0, m_c;
    logic [15:0] m_a, m_b;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(16), .BIG_ENDIAN(0)) u16 (
        .clk(clk), .reset(reset), .ready(rdy[0]), .mode(mode_i), .e(e_i[15:0]), .d(d_i[15:0]),
        .n(n_i[15:0]), .C_in(c_i[15:0]), .m_out(m_a), .valid(vld[0]), .err(er[0]), .busy(bsy[0]));
    rsa_modexp_core #(.WIDTH(16), .BIG_ENDIAN(1)) ube (
        .clk(clk), .reset(reset), .ready(rdy[1]), .mode(mode_i), .e(e_i[15:0]), .d(d_i[15:0]),
        .n(n_i[15:0]), .C_in(c_i[15:0]), .m_out(m_b), .valid(vld[1]), .err(er[1]), .busy(bsy[1]));
    rsa_modexp_core #(.WIDTH(32), .BIG_ENDIAN(0)) u32 (
        .clk(clk), .reset(reset), .ready(rdy[2]), .mode(mode_i), .e(e_i), .d(d_i),
        .n(n_i), .C_in(c_i), .m_out(m_c), .valid(vld[2]), .err(er[2]), .busy(bsy[2]));

    typedef struct {
        int          sel;
        logic        md;
        logic [31:0] e, d, n, c, m;
        logic        er;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [31:0] mo(input int sel);
        return (sel == 0) ? {16'b0, m_a} : (sel == 1) ? {16'b0, m_b} : m_c;
    endfunction

    // Reference: plain 64-bit square-and-multiply on integers
    function automatic logic [31:0] mexp(input logic [31:0] x, input logic [31:0] ex, input logic [31:0] nn);
        longint unsigned r = 1, b = 64'(x);
        for (int i = 0; i < 32; i++) begin
            if (ex[i]) r = (r * b) % 64'(nn);
            b = (b * b) % 64'(nn);
        end
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", nm, act, act, exp, exp);
        end
    endtask

    // Issues one request at a negedge and waits (bounded) for valid; latency counted in edges from the accept edge
    task automatic run(input int sel, input logic md, input logic [31:0] ee, input logic [31:0] dd,
                       input logic [31:0] nn, input logic [31:0] cc, input logic [31:0] em, input logic eerr,
                       input int elat, input bit hold, input bit noise, input string tag);
        int k = 0;
        bit got = 0;
        mode_i = md; e_i = ee; d_i = dd; n_i = nn; c_i = cc;
        rdy[sel] = 1'b1;
        for (int t = 0; t < 1100 && !got; t++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (vld[sel]) got = 1;
            else if (!hold) rdy[sel] = noise && (k % 5 == 2);
        end
        if (!hold) rdy[sel] = 1'b0;
        chk({tag, "_valid"}, {31'b0, got}, 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(elat));
        chk({tag, "_m_out"}, mo(sel), em);
        chk({tag, "_err"}, {31'b0, er[sel]}, {31'b0, eerr});
        if (!hold) begin
            @(negedge clk);
            chk({tag, "_busy_low"}, {31'b0, bsy[sel]}, 32'd0);
        end
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{0, 1'b0, 17, 2753, 3233, 65, 2790, 1'b0, 87};
        tbl[1]  = '{0, 1'b1, 17, 2753, 3233, 2790, 65, 1'b0, 206};
        tbl[2]  = '{0, 1'b0, 17, 2753, 3233, 3233, 0, 1'b1, 2};
        tbl[3]  = '{0, 1'b0, 17, 2753, 1, 0, 0, 1'b1, 2};
        tbl[4]  = '{0, 1'b0, 0, 2753, 3233, 5, 1, 1'b0, 2};
        tbl[5]  = '{0, 1'b0, 17, 2753, 0, 0, 0, 1'b1, 2};
        tbl[6]  = '{0, 1'b1, 17, 1, 3233, 123, 123, 1'b0, 19};
        tbl[7]  = '{0, 1'b0, 2, 2753, 3233, 3232, 1, 1'b0, 36};
        tbl[8]  = '{1, 1'b1, 17, 2753, 3233, 32'hE60A, 32'h4100, 1'b0, 206};
        tbl[9]  = '{1, 1'b0, 17, 2753, 3233, 32'h4100, 32'hE60A, 1'b0, 87};
        tbl[10] = '{1, 1'b0, 17, 2753, 3233, 32'hA10C, 0, 1'b1, 2};
        tbl[11] = '{1, 1'b0, 0, 2753, 3233, 32'h0500, 32'h0100, 1'b0, 2};
        tbl[12] = '{0, 1'b0, 17, 2753, 3233, 65, 2790, 1'b0, 87};
        tbl[13] = '{1, 1'b0, 17, 2753, 3233, 32'h4100, 32'hE60A, 1'b0, 87};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_m_out%0d", s), mo(s), 32'd0);
            chk($sformatf("reset_valid%0d", s), {31'b0, vld[s]}, 32'd0);
            chk($sformatf("reset_err%0d", s), {31'b0, er[s]}, 32'd0);
            chk($sformatf("reset_busy%0d", s), {31'b0, bsy[s]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run(tbl[i].sel, tbl[i].md, tbl[i].e, tbl[i].d, tbl[i].n, tbl[i].c, tbl[i].m, tbl[i].er,
                tbl[i].lat, 0, 0, $sformatf("vec%0d", i));

        run(0, 1'b1, 17, 2753, 3233, 2790, 65, 1'b0, 206, 0, 1, "noisy_ready");
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (vld[0]) cnt++;
        end
        chk("noisy_extra_valid", 32'(cnt), 32'd0);

        mode_i = 1'b1; e_i = 17; d_i = 2753; n_i = 3233; c_i = 2790;
        rdy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[0] = 1'b0;
        repeat (39) @(negedge clk);
        chk("mid_busy", {31'b0, bsy[0]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, bsy[0]}, 32'd0);
        chk("abort_valid", {31'b0, vld[0]}, 32'd0);
        chk("abort_m_out", mo(0), 32'd0);
        chk("abort_err", {31'b0, er[0]}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (vld[0]) cnt++;
        end
        chk("abort_no_valid", 32'(cnt), 32'd0);
        run(0, 1'b0, 17, 2753, 3233, 65, 2790, 1'b0, 87, 0, 0, "after_reset");

        for (int i = 0; i < 30; i++) begin
            logic [31:0] nn, x, ee, dd, ex, em;
            logic        md, eerr;
            int          k, lat, l;
            do nn = $urandom; while (nn < 2);
            k  = $urandom_range(0, 9);
            x  = (k == 0) ? nn : $urandom % nn;
            ee = (k == 1) ? 0 : $urandom >> $urandom_range(0, 31);
            dd = (k == 2) ? 0 : $urandom >> $urandom_range(0, 31);
            md = 1'($urandom_range(0, 1));
            ex = md ? dd : ee;
            eerr = x >= nn;
            l = 0;
            for (int b = 0; b < 32; b++) if (ex[b]) l = b + 1;
            em  = eerr ? 0 : (ex == 0) ? 1 : mexp(x, ex, nn);
            lat = (eerr || ex == 0) ? 2 : 2 + l * 33;
            run(2, md, ee, dd, nn, x, em, eerr, lat + (i > 0 ? 1 : 0), 1, 0, $sformatf("rand%0d", i));
        end
        rdy[2] = 1'b0;
        @(negedge clk);
        chk("rand_busy_low", {31'b0, bsy[2]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
